// File: rtl/ysyx_22050550_axi_pkg.sv
// Shared types and constants for the AXI line master: FSM states, AXI burst
// attribute encodings and the beat-index width helper.
package ysyx_22050550_axi_pkg;

    typedef enum logic [2:0] {
        ST_IDLE = 3'd0,
        ST_AR   = 3'd1,
        ST_R    = 3'd2,
        ST_AW   = 3'd3,
        ST_W    = 3'd4,
        ST_RESP = 3'd5
    } state_e;

    localparam logic [1:0] AXI_BURST_INCR = 2'b01;
    localparam logic [2:0] AXI_SIZE_8B    = 3'b011;

    // Width of an index selecting one beat of a line; never narrower than 1 bit.
    function automatic int beat_idx_w(input int beats);
        return (beats > 1) ? $clog2(beats) : 1;
    endfunction

endpackage

// File: rtl/ysyx_22050550_axi_line_master_if.sv
// AXI-style bus between the line master and the SRAM responder. There is no
// B channel: writes complete on the final W handshake.
interface ysyx_22050550_axi_line_master_if;

    logic        io_Sram_ar_valid;
    logic [63:0] io_Sram_ar_bits_addr;
    logic [7:0]  io_ar_len;
    logic [2:0]  io_ar_size;
    logic [1:0]  io_ar_burst;
    logic        io_Sram_ar_ready;

    logic        io_Sram_r_valid;
    logic [63:0] io_Sram_r_bits_data;
    logic        io_Sram_r_bits_last;
    logic        io_Sram_r_ready;

    logic        io_Sram_aw_valid;
    logic [63:0] io_Sram_aw_bits_addr;
    logic [7:0]  io_aw_len;
    logic [2:0]  io_aw_size;
    logic [1:0]  io_aw_burst;
    logic        io_Sram_aw_ready;

    logic        io_Sram_w_valid;
    logic [63:0] io_Sram_w_bits_data;
    logic [7:0]  io_Sram_w_bits_strb;
    logic        io_Sram_w_ready;

    modport master (
        output io_Sram_ar_valid, io_Sram_ar_bits_addr, io_ar_len, io_ar_size, io_ar_burst,
        input  io_Sram_ar_ready,
        input  io_Sram_r_valid, io_Sram_r_bits_data, io_Sram_r_bits_last,
        output io_Sram_r_ready,
        output io_Sram_aw_valid, io_Sram_aw_bits_addr, io_aw_len, io_aw_size, io_aw_burst,
        input  io_Sram_aw_ready,
        output io_Sram_w_valid, io_Sram_w_bits_data, io_Sram_w_bits_strb,
        input  io_Sram_w_ready
    );

    modport slave (
        input  io_Sram_ar_valid, io_Sram_ar_bits_addr, io_ar_len, io_ar_size, io_ar_burst,
        output io_Sram_ar_ready,
        output io_Sram_r_valid, io_Sram_r_bits_data, io_Sram_r_bits_last,
        input  io_Sram_r_ready,
        input  io_Sram_aw_valid, io_Sram_aw_bits_addr, io_aw_len, io_aw_size, io_aw_burst,
        output io_Sram_aw_ready,
        input  io_Sram_w_valid, io_Sram_w_bits_data, io_Sram_w_bits_strb,
        output io_Sram_w_ready
    );

endinterface

// File: rtl/ysyx_22050550_line_buffer.sv
// One cache line held as LINE_BEATS 64-bit beats: indexed beat write for
// returning read data, indexed beat read for outgoing write data, full-line
// load from the cache and a synchronous clear.
module ysyx_22050550_line_buffer
    import ysyx_22050550_axi_pkg::*;
#(
    parameter  int LINE_BEATS = 2,
    localparam int IDX_W      = beat_idx_w(LINE_BEATS),
    localparam int LINE_W     = 64 * LINE_BEATS
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              clear,
    input  logic              load,
    input  logic [LINE_W-1:0] load_line,
    input  logic              wr_en,
    input  logic [IDX_W-1:0]  wr_idx,
    input  logic [63:0]       wr_data,
    input  logic [IDX_W-1:0]  rd_idx,
    output logic [63:0]       rd_data,
    output logic [LINE_W-1:0] line
);

    logic [63:0] beats_q [LINE_BEATS];

    // Beat storage update: clear wins over a line load, which wins over a beat write.
    // NOTE: the array is reset on purpose -- a read response must show zeros, not
    // stale X, in slots the responder never wrote. Sequential state uses <= only.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < LINE_BEATS; i++) beats_q[i] <= '0;
        end else if (clear) begin
            for (int i = 0; i < LINE_BEATS; i++) beats_q[i] <= '0;
        end else if (load) begin
            for (int i = 0; i < LINE_BEATS; i++) beats_q[i] <= load_line[i*64 +: 64];
        end else if (wr_en) begin
            beats_q[wr_idx] <= wr_data;
        end
    end

    // Flatten the beats into a line, beat 0 in the low 64 bits.
    // NOTE: every output of an always_comb gets a default first so no latch is inferred.
    always_comb begin
        line = '0;
        for (int i = 0; i < LINE_BEATS; i++) line[i*64 +: 64] = beats_q[i];
    end

    assign rd_data = beats_q[rd_idx];

endmodule

// File: rtl/ysyx_22050550_axi_line_master.sv
// Cache-side AXI initiator: turns one request into a full-line INCR burst or
// a single-beat uncached access, and returns a one-cycle completion pulse.
module ysyx_22050550_axi_line_master
    import ysyx_22050550_axi_pkg::*;
#(
    parameter  int LINE_BEATS = 2,
    parameter  int ADDR_W     = 64,
    localparam int LINE_W     = 64 * LINE_BEATS
) (
    input  logic              clock,
    input  logic              reset,

    input  logic              req_valid,
    output logic              req_ready,
    input  logic              req_write,
    input  logic              req_line,
    input  logic [ADDR_W-1:0] req_addr,
    input  logic [2:0]        req_size,
    input  logic [LINE_W-1:0] req_wdata,
    input  logic [7:0]        req_wstrb,
    output logic              resp_valid,
    output logic [LINE_W-1:0] resp_rdata,

    ysyx_22050550_axi_line_master_if.master bus,

    output logic              proto_err
);

    localparam int IDX_W = beat_idx_w(LINE_BEATS);
    localparam int CNT_W = $clog2(LINE_BEATS) + 1;
    localparam int OFF_W = $clog2(LINE_BEATS * 8);
    localparam logic [ADDR_W-1:0] LINE_MASK = ~ADDR_W'((64'd1 << OFF_W) - 64'd1);

    state_e              state_q;
    logic [CNT_W-1:0]    cnt_q;
    logic [ADDR_W-1:0]   addr_q;
    logic [2:0]          size_q;
    logic [7:0]          len_q;
    logic                line_q;
    logic                write_q;
    logic [7:0]          wstrb_q;
    logic                proto_err_q;
    logic [LINE_W-1:0]   resp_rdata_q;

    logic                ar_hs, r_hs, aw_hs, w_hs, last_beat, accept;
    logic [63:0]         buf_rd_data;
    logic [LINE_W-1:0]   buf_line;

    assign accept    = (state_q == ST_IDLE) && req_valid;
    assign ar_hs     = bus.io_Sram_ar_valid && bus.io_Sram_ar_ready;
    assign r_hs      = bus.io_Sram_r_valid  && bus.io_Sram_r_ready;
    assign aw_hs     = bus.io_Sram_aw_valid && bus.io_Sram_aw_ready;
    assign w_hs      = bus.io_Sram_w_valid  && bus.io_Sram_w_ready;
    // The counter exits at len, so it never needs to wrap past LINE_BEATS.
    assign last_beat = (8'(cnt_q) == len_q);

    // Handshake outputs come straight from the state so a reset drops them at once.
    assign req_ready                = (state_q == ST_IDLE);
    assign bus.io_Sram_ar_valid     = (state_q == ST_AR);
    assign bus.io_Sram_r_ready      = (state_q == ST_R);
    assign bus.io_Sram_aw_valid     = (state_q == ST_AW);
    assign bus.io_Sram_w_valid      = (state_q == ST_W);
    assign resp_valid               = (state_q == ST_RESP);
    assign proto_err                = proto_err_q;

    // Both address channels carry the same latched burst description.
    assign bus.io_Sram_ar_bits_addr = 64'(addr_q);
    assign bus.io_ar_len            = len_q;
    assign bus.io_ar_size           = size_q;
    assign bus.io_ar_burst          = AXI_BURST_INCR;
    assign bus.io_Sram_aw_bits_addr = 64'(addr_q);
    assign bus.io_aw_len            = len_q;
    assign bus.io_aw_size           = size_q;
    assign bus.io_aw_burst          = AXI_BURST_INCR;

    assign bus.io_Sram_w_bits_data  = buf_rd_data;
    assign bus.io_Sram_w_bits_strb  = line_q ? 8'hFF : wstrb_q;

    // During RESP a read shows the freshly filled buffer; otherwise the last read line.
    assign resp_rdata = (state_q == ST_RESP && !write_q) ? buf_line : resp_rdata_q;

    ysyx_22050550_line_buffer #(
        .LINE_BEATS (LINE_BEATS)
    ) u_line_buffer (
        .clock     (clock),
        .reset     (reset),
        // A single read keeps only slot 0, so the rest are cleared before data returns.
        .clear     (ar_hs && !line_q),
        .load      (accept && req_write),
        .load_line (req_wdata),
        .wr_en     (r_hs),
        .wr_idx    (cnt_q[IDX_W-1:0]),
        .wr_data   (bus.io_Sram_r_bits_data),
        .rd_idx    (cnt_q[IDX_W-1:0]),
        .rd_data   (buf_rd_data),
        .line      (buf_line)
    );

    // Transaction FSM: latch the request, run the address phase, then count beats.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_q     <= ST_IDLE;
            cnt_q       <= '0;
            addr_q      <= '0;
            size_q      <= '0;
            len_q       <= '0;
            line_q      <= 1'b0;
            write_q     <= 1'b0;
            wstrb_q     <= '0;
            proto_err_q <= 1'b0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (req_valid) begin
                        addr_q  <= req_line ? (req_addr & LINE_MASK) : req_addr;
                        size_q  <= req_line ? AXI_SIZE_8B : req_size;
                        len_q   <= req_line ? 8'(LINE_BEATS - 1) : 8'd0;
                        line_q  <= req_line;
                        write_q <= req_write;
                        wstrb_q <= req_wstrb;
                        state_q <= req_write ? ST_AW : ST_AR;
                    end
                end
                ST_AR: begin
                    if (ar_hs) begin
                        cnt_q   <= '0;
                        state_q <= ST_R;
                    end
                end
                ST_R: begin
                    if (r_hs) begin
                        cnt_q <= cnt_q + CNT_W'(1);
                        // The responder's last flag is only audited; the count decides the end.
                        if (bus.io_Sram_r_bits_last != last_beat) proto_err_q <= 1'b1;
                        if (last_beat) state_q <= ST_RESP;
                    end
                end
                ST_AW: begin
                    if (aw_hs) begin
                        cnt_q   <= '0;
                        state_q <= ST_W;
                    end
                end
                ST_W: begin
                    if (w_hs) begin
                        cnt_q <= cnt_q + CNT_W'(1);
                        if (last_beat) state_q <= ST_RESP;
                    end
                end
                ST_RESP: state_q <= ST_IDLE;
                default: state_q <= ST_IDLE;
            endcase
        end
    end

    // Hold the returned read line after RESP so the cache can sample it later.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            resp_rdata_q <= '0;
        end else if (state_q == ST_RESP && !write_q) begin
            resp_rdata_q <= buf_line;
        end
    end

endmodule

// File: tb/tb_ysyx_22050550_axi_line_master.sv
// Scoreboard bench for the AXI line master: directed requests push expected
// AR/AW/W/response records; a negedge monitor pops and compares them.
`timescale 1ns/1ps
module tb_ysyx_22050550_axi_line_master;

    localparam int LINE_BEATS = 2;
    localparam int LINE_W     = 64 * LINE_BEATS;

    logic              clock = 1'b0;
    logic              reset = 1'b1;
    logic              req_valid = 1'b0;
    logic              req_ready;
    logic              req_write = 1'b0;
    logic              req_line = 1'b0;
    logic [63:0]       req_addr = '0;
    logic [2:0]        req_size = '0;
    logic [LINE_W-1:0] req_wdata = '0;
    logic [7:0]        req_wstrb = '0;
    logic              resp_valid;
    logic [LINE_W-1:0] resp_rdata;
    logic              proto_err;

    always #5 clock = ~clock;

    ysyx_22050550_axi_line_master_if axi();

    ysyx_22050550_axi_line_master #(.LINE_BEATS(LINE_BEATS), .ADDR_W(64)) dut (
        .clock      (clock),
        .reset      (reset),
        .req_valid  (req_valid),
        .req_ready  (req_ready),
        .req_write  (req_write),
        .req_line   (req_line),
        .req_addr   (req_addr),
        .req_size   (req_size),
        .req_wdata  (req_wdata),
        .req_wstrb  (req_wstrb),
        .resp_valid (resp_valid),
        .resp_rdata (resp_rdata),
        .bus        (axi),
        .proto_err  (proto_err)
    );

    typedef struct { logic [63:0] addr; logic [7:0] len; logic [2:0] size; logic [1:0] burst; } addr_exp_t;
    typedef struct { logic [63:0] data; logic [7:0] strb; } w_exp_t;
    typedef struct { logic [LINE_W-1:0] rdata; int lat; } resp_exp_t;
    typedef struct { logic [63:0] data; logic last; } r_beat_t;

    addr_exp_t exp_ar[$];
    addr_exp_t exp_aw[$];
    w_exp_t    exp_w[$];
    resp_exp_t exp_resp[$];
    r_beat_t   r_beats[$];

    int checks = 0;
    int errors = 0;

    task automatic check(input string name, input logic [255:0] act, input logic [255:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h", name, act, req);
        end
    endtask

    // ---------------- monitor ----------------
    int        cyc = 0;
    int        accept_cyc = 0;
    int        resp_seen = 0;
    int        r_hs_cnt = 0;
    logic      ar_hs_s = 0, r_hs_s = 0, aw_hs_s = 0, aw_valid_s = 0, w_hs_s = 0;
    logic      aw_done = 0;
    addr_exp_t tmp_a;
    w_exp_t    tmp_w;
    resp_exp_t tmp_r;

    always @(posedge clock) cyc++;

    always @(negedge clock) begin
        ar_hs_s    = axi.io_Sram_ar_valid && axi.io_Sram_ar_ready;
        r_hs_s     = axi.io_Sram_r_valid  && axi.io_Sram_r_ready;
        aw_valid_s = axi.io_Sram_aw_valid;
        aw_hs_s    = axi.io_Sram_aw_valid && axi.io_Sram_aw_ready;
        w_hs_s     = axi.io_Sram_w_valid  && axi.io_Sram_w_ready;
        if (!reset) aw_done = 0;
        if (req_valid && req_ready) accept_cyc = cyc;
        if (ar_hs_s) begin
            if (exp_ar.size() == 0) check("ar_pending", exp_ar.size(), 1);
            else begin
                tmp_a = exp_ar.pop_front();
                check("ar_addr",  axi.io_Sram_ar_bits_addr, tmp_a.addr);
                check("ar_len",   axi.io_ar_len,   tmp_a.len);
                check("ar_size",  axi.io_ar_size,  tmp_a.size);
                check("ar_burst", axi.io_ar_burst, tmp_a.burst);
            end
        end
        if (r_hs_s) r_hs_cnt++;
        if (aw_hs_s) begin
            aw_done = 1;
            if (exp_aw.size() == 0) check("aw_pending", exp_aw.size(), 1);
            else begin
                tmp_a = exp_aw.pop_front();
                check("aw_addr",  axi.io_Sram_aw_bits_addr, tmp_a.addr);
                check("aw_len",   axi.io_aw_len,   tmp_a.len);
                check("aw_size",  axi.io_aw_size,  tmp_a.size);
                check("aw_burst", axi.io_aw_burst, tmp_a.burst);
            end
        end
        if (axi.io_Sram_w_valid) check("w_after_aw", aw_done, 1);
        if (w_hs_s) begin
            if (exp_w.size() == 0) check("w_pending", exp_w.size(), 1);
            else begin
                tmp_w = exp_w.pop_front();
                check("w_data", axi.io_Sram_w_bits_data, tmp_w.data);
                check("w_strb", axi.io_Sram_w_bits_strb, tmp_w.strb);
            end
        end
        if (resp_valid) begin
            resp_seen++;
            aw_done = 0;
            if (exp_resp.size() == 0) check("resp_pending", exp_resp.size(), 1);
            else begin
                tmp_r = exp_resp.pop_front();
                check("resp_rdata", resp_rdata, tmp_r.rdata);
                // Inclusive cycle count from the accept cycle to the resp_valid cycle.
                if (tmp_r.lat > 0) check("resp_latency", cyc - accept_cyc + 1, tmp_r.lat);
            end
        end
    end

    // ---------------- responder ----------------
    int      aw_delay = 0, aw_cnt = 0;
    int      w_stall_after = 0, w_stall_cycles = 0, w_done = 0, w_rem = 0;
    logic    r_active = 0;
    r_beat_t tmp_b;

    initial begin
        axi.io_Sram_ar_ready    = 1'b1;
        axi.io_Sram_r_valid     = 1'b0;
        axi.io_Sram_r_bits_data = '0;
        axi.io_Sram_r_bits_last = 1'b0;
        axi.io_Sram_aw_ready    = 1'b1;
        axi.io_Sram_w_ready     = 1'b1;
        forever begin
            @(posedge clock);
            #1;
            if (!reset) begin
                axi.io_Sram_r_valid = 1'b0;
                r_beats.delete();
                r_active = 0;
                aw_cnt   = 0;
                w_rem    = 0;
            end else begin
                if (r_hs_s && r_beats.size() > 0) tmp_b = r_beats.pop_front();
                if (ar_hs_s) r_active = 1;
                if (r_active && r_beats.size() > 0) begin
                    axi.io_Sram_r_valid     = 1'b1;
                    axi.io_Sram_r_bits_data = r_beats[0].data;
                    axi.io_Sram_r_bits_last = r_beats[0].last;
                end else begin
                    axi.io_Sram_r_valid = 1'b0;
                    r_active = 0;
                end
                if (aw_delay == 0) axi.io_Sram_aw_ready = 1'b1;
                else if (aw_hs_s) begin aw_cnt = 0; axi.io_Sram_aw_ready = 1'b0; end
                else if (aw_valid_s) begin aw_cnt++; axi.io_Sram_aw_ready = (aw_cnt >= aw_delay); end
                else begin aw_cnt = 0; axi.io_Sram_aw_ready = 1'b0; end
                if (w_hs_s) begin
                    w_done++;
                    if (w_done == w_stall_after) w_rem = w_stall_cycles;
                end
                if (w_rem > 0) begin axi.io_Sram_w_ready = 1'b0; w_rem--; end
                else axi.io_Sram_w_ready = 1'b1;
            end
        end
    end

    // ---------------- stimulus ----------------
    task automatic issue(input logic wr, input logic ln, input logic [63:0] addr,
                         input logic [2:0] size, input logic [LINE_W-1:0] wdata, input logic [7:0] strb);
        int n;
        @(posedge clock);
        #1;
        req_valid = 1'b1; req_write = wr; req_line = ln; req_addr = addr;
        req_size = size; req_wdata = wdata; req_wstrb = strb;
        n = 0;
        @(negedge clock);
        while (!req_ready && n < 100) begin @(negedge clock); n++; end
        if (!req_ready) check("req_ready_timeout", req_ready, 1);
        @(posedge clock);
        #1;
        req_valid = 1'b0;
    endtask

    task automatic wait_resp(input int target);
        int n;
        n = 0;
        while (resp_seen < target && n < 200) begin @(posedge clock); #1; n++; end
        check("resp_count", resp_seen, target);
    endtask

    function automatic addr_exp_t mk_a(input logic [63:0] a, input logic [7:0] l, input logic [2:0] s);
        addr_exp_t e;
        e.addr = a; e.len = l; e.size = s; e.burst = 2'b01;
        return e;
    endfunction

    function automatic r_beat_t mk_b(input logic [63:0] d, input logic l);
        r_beat_t b;
        b.data = d; b.last = l;
        return b;
    endfunction

    function automatic resp_exp_t mk_r(input logic [LINE_W-1:0] d, input int lat);
        resp_exp_t r;
        r.rdata = d; r.lat = lat;
        return r;
    endfunction

    function automatic w_exp_t mk_w(input logic [63:0] d, input logic [7:0] s);
        w_exp_t w;
        w.data = d; w.strb = s;
        return w;
    endfunction

    initial begin
        #1 reset = 1'b0;
        #6;
        check("rst_req_ready",  req_ready, 1);
        check("rst_ar_valid",   axi.io_Sram_ar_valid, 0);
        check("rst_r_ready",    axi.io_Sram_r_ready, 0);
        check("rst_aw_valid",   axi.io_Sram_aw_valid, 0);
        check("rst_w_valid",    axi.io_Sram_w_valid, 0);
        check("rst_resp_valid", resp_valid, 0);
        check("rst_proto_err",  proto_err, 0);
        check("rst_resp_rdata", resp_rdata, 0);
        repeat (2) @(negedge clock);
        reset = 1'b1;

        // Line read, unaligned address
        exp_ar.push_back(mk_a(64'h8000_0010, 8'd1, 3'd3));
        r_beats.push_back(mk_b(64'h1111, 1'b0));
        r_beats.push_back(mk_b(64'h2222, 1'b1));
        exp_resp.push_back(mk_r({64'h2222, 64'h1111}, 5));
        issue(1'b0, 1'b1, 64'h8000_0013, 3'd0, '0, 8'h00);
        wait_resp(1);

        // Single read, size 2
        exp_ar.push_back(mk_a(64'h8000_0004, 8'd0, 3'd2));
        r_beats.push_back(mk_b(64'hDEAD_BEEF, 1'b1));
        exp_resp.push_back(mk_r({64'h0, 64'hDEAD_BEEF}, 4));
        issue(1'b0, 1'b0, 64'h8000_0004, 3'd2, '0, 8'h00);
        wait_resp(2);

        // Line write with AW delay and a mid-burst W stall
        aw_delay = 3; w_done = 0; w_stall_after = 1; w_stall_cycles = 2;
        exp_aw.push_back(mk_a(64'h8000_0020, 8'd1, 3'd3));
        exp_w.push_back(mk_w(64'hAAAA, 8'hFF));
        exp_w.push_back(mk_w(64'hBBBB, 8'hFF));
        exp_resp.push_back(mk_r({64'h0, 64'hDEAD_BEEF}, 0));
        issue(1'b1, 1'b1, 64'h8000_0028, 3'd0, {64'hBBBB, 64'hAAAA}, 8'h00);
        wait_resp(3);

        // Single write, byte strobe
        aw_delay = 0; w_done = 0; w_stall_after = 0; w_stall_cycles = 0;
        exp_aw.push_back(mk_a(64'h8000_0102, 8'd0, 3'd0));
        exp_w.push_back(mk_w(64'h0000_0000_00CC_0000, 8'h04));
        exp_resp.push_back(mk_r({64'h0, 64'hDEAD_BEEF}, 4));
        issue(1'b1, 1'b0, 64'h8000_0102, 3'd0, {64'h5A5A, 64'h0000_0000_00CC_0000}, 8'h04);
        wait_resp(4);
        check("proto_err_clean", proto_err, 0);

        // Early r_last on beat 0 of a line burst
        exp_ar.push_back(mk_a(64'h8000_0040, 8'd1, 3'd3));
        r_beats.push_back(mk_b(64'h3333, 1'b1));
        r_beats.push_back(mk_b(64'h4444, 1'b0));
        exp_resp.push_back(mk_r({64'h4444, 64'h3333}, 5));
        issue(1'b0, 1'b1, 64'h8000_0040, 3'd0, '0, 8'h00);
        wait_resp(5);
        check("proto_err_set", proto_err, 1);
        exp_ar.push_back(mk_a(64'h8000_0048, 8'd0, 3'd3));
        r_beats.push_back(mk_b(64'h5555, 1'b1));
        exp_resp.push_back(mk_r({64'h0, 64'h5555}, 4));
        issue(1'b0, 1'b0, 64'h8000_0048, 3'd3, '0, 8'h00);
        wait_resp(6);
        check("proto_err_sticky", proto_err, 1);

        // Reset while in R after the first beat
        begin
            int base, n;
            base = r_hs_cnt;
            exp_ar.push_back(mk_a(64'h8000_0080, 8'd1, 3'd3));
            r_beats.push_back(mk_b(64'h6666, 1'b0));
            r_beats.push_back(mk_b(64'h7777, 1'b1));
            issue(1'b0, 1'b1, 64'h8000_0080, 3'd0, '0, 8'h00);
            n = 0;
            while (r_hs_cnt == base && n < 50) begin @(posedge clock); #1; n++; end
            check("beat0_seen", r_hs_cnt, base + 1);
            #1 reset = 1'b0;
            #1;
            check("mid_rst_ar_valid",   axi.io_Sram_ar_valid, 0);
            check("mid_rst_r_ready",    axi.io_Sram_r_ready, 0);
            check("mid_rst_aw_valid",   axi.io_Sram_aw_valid, 0);
            check("mid_rst_w_valid",    axi.io_Sram_w_valid, 0);
            check("mid_rst_resp_valid", resp_valid, 0);
            check("mid_rst_req_ready",  req_ready, 1);
            check("mid_rst_proto_err",  proto_err, 0);
            check("mid_rst_resp_rdata", resp_rdata, 0);
            repeat (3) @(negedge clock);
            reset = 1'b1;
            repeat (2) @(negedge clock);
            check("no_resp_after_rst", resp_seen, 6);
        end

        exp_ar.push_back(mk_a(64'h8000_0090, 8'd0, 3'd3));
        r_beats.push_back(mk_b(64'h9999, 1'b1));
        exp_resp.push_back(mk_r({64'h0, 64'h9999}, 4));
        issue(1'b0, 1'b0, 64'h8000_0090, 3'd3, '0, 8'h00);
        wait_resp(7);
        check("proto_err_after_rst", proto_err, 0);

        repeat (3) @(posedge clock);
        check("ar_left",   exp_ar.size(), 0);
        check("aw_left",   exp_aw.size(), 0);
        check("w_left",    exp_w.size(), 0);
        check("resp_left", exp_resp.size(), 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog expired");
    end

endmodule
